// File: rtl/forwarding_unit.sv
// forwarding_unit: operand-forwarding select and load-use stall unit for the
// RV32IM 5-stage pipeline. It shadows the destination-register state of the
// EX, MEM and WB stages. It registers the two EX operand-mux selects, one
// cycle after the instruction is seen in ID.
//   select 00 = register file, 01 = EX/MEM ALU result,
//          10 = MEM/WB write-back value, 11 = retired write-back buffer
module forwarding_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ID_VALID,
   input  logic [REG_ADDR_W-1:0] ID_RS1,
   input  logic [REG_ADDR_W-1:0] ID_RS2,
   input  logic [REG_ADDR_W-1:0] ID_RD,
   input  logic                  ID_REG_WRITE_EN,
   input  logic                  ID_MEM_READ,
   input  logic                  FLUSH,
   output logic [1:0]            OP1_SELECT,
   output logic [1:0]            OP2_SELECT,
   output logic                  STALL
);

   // Stage records. The load flag only affects hazard detection while the
   // producer sits in EX, so MEM and WB keep only {rd, we}.
   logic [REG_ADDR_W-1:0] ex_rd_r;
   logic                  ex_we_r;
   logic                  ex_ld_r;
   logic [REG_ADDR_W-1:0] mem_rd_r;
   logic                  mem_we_r;
   logic [REG_ADDR_W-1:0] wb_rd_r;
   logic                  wb_we_r;

   logic                  ex_eff_s;
   logic                  mem_eff_s;
   logic                  wb_eff_s;
   logic                  stall_s;
   logic                  kill_s;
   logic [1:0]            op1_sel_s;
   logic [1:0]            op2_sel_s;

   // Youngest-producer-first select for one source operand. x0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  ex_eff,
      input logic [REG_ADDR_W-1:0] ex_rd,
      input logic                  mem_eff,
      input logic [REG_ADDR_W-1:0] mem_rd,
      input logic                  wb_eff,
      input logic [REG_ADDR_W-1:0] wb_rd
   );
      logic [1:0] sel;
      if (rs == {REG_ADDR_W{1'b0}}) begin
         sel = 2'b00;
      end else if (ex_eff && (ex_rd == rs)) begin
         sel = 2'b01;
      end else if (mem_eff && (mem_rd == rs)) begin
         sel = 2'b10;
      end else if (wb_eff && (wb_rd == rs)) begin
         sel = 2'b11;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Effective-write flags, load-use stall and next select codes.
   always_comb begin
      ex_eff_s  = ex_we_r  & (ex_rd_r  != {REG_ADDR_W{1'b0}});
      mem_eff_s = mem_we_r & (mem_rd_r != {REG_ADDR_W{1'b0}});
      wb_eff_s  = wb_we_r  & (wb_rd_r  != {REG_ADDR_W{1'b0}});
      stall_s   = ID_VALID & ~FLUSH & ex_ld_r & ex_eff_s &
                  ((ex_rd_r == ID_RS1) | (ex_rd_r == ID_RS2));
      kill_s    = FLUSH | stall_s | ~ID_VALID;
      op1_sel_s = fwd_sel(ID_RS1, ex_eff_s, ex_rd_r, mem_eff_s, mem_rd_r,
                          wb_eff_s, wb_rd_r);
      op2_sel_s = fwd_sel(ID_RS2, ex_eff_s, ex_rd_r, mem_eff_s, mem_rd_r,
                          wb_eff_s, wb_rd_r);
   end

   assign STALL = stall_s;

   // Advance the pipeline shadow. ID enters EX unless it is killed, stalled or absent.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         ex_rd_r    <= {REG_ADDR_W{1'b0}};
         ex_we_r    <= 1'b0;
         ex_ld_r    <= 1'b0;
         mem_rd_r   <= {REG_ADDR_W{1'b0}};
         mem_we_r   <= 1'b0;
         wb_rd_r    <= {REG_ADDR_W{1'b0}};
         wb_we_r    <= 1'b0;
         OP1_SELECT <= 2'b00;
         OP2_SELECT <= 2'b00;
      end else begin
         mem_rd_r <= ex_rd_r;
         mem_we_r <= ex_we_r;
         wb_rd_r  <= mem_rd_r;
         wb_we_r  <= mem_we_r;
         if (kill_s) begin
            ex_rd_r    <= {REG_ADDR_W{1'b0}};
            ex_we_r    <= 1'b0;
            ex_ld_r    <= 1'b0;
            OP1_SELECT <= 2'b00;
            OP2_SELECT <= 2'b00;
         end else begin
            ex_rd_r    <= ID_RD;
            ex_we_r    <= ID_REG_WRITE_EN;
            ex_ld_r    <= ID_MEM_READ;
            OP1_SELECT <= op1_sel_s;
            OP2_SELECT <= op2_sel_s;
         end
      end
   end

endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: table-driven directed bench for forwarding_unit.
// Each row is one ID-stage instruction. The bench checks STALL before the edge
// and the registered selects after the edge. The expected values come from
// tracking the pipeline by hand.
module tb_forwarding_unit;

   logic       CLK;
   logic       RESET;
   logic       ID_VALID;
   logic [4:0] ID_RS1;
   logic [4:0] ID_RS2;
   logic [4:0] ID_RD;
   logic       ID_REG_WRITE_EN;
   logic       ID_MEM_READ;
   logic       FLUSH;
   logic [1:0] OP1_SELECT;
   logic [1:0] OP2_SELECT;
   logic       STALL;

   int checks;
   int errors;

   forwarding_unit #(.REG_ADDR_W(5)) dut (
      .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1),
      .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_REG_WRITE_EN(ID_REG_WRITE_EN),
      .ID_MEM_READ(ID_MEM_READ), .FLUSH(FLUSH), .OP1_SELECT(OP1_SELECT),
      .OP2_SELECT(OP2_SELECT), .STALL(STALL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic       fl;
      logic       stall;
      logic [1:0] op1;
      logic [1:0] op2;
   } vec_t;

   localparam int NV = 32;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic fl, input logic stall,
                               input logic [1:0] op1, input logic [1:0] op2);
      vec_t r;
      r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.we = we; r.ld = ld;
      r.fl = fl; r.stall = stall; r.op1 = op1; r.op2 = op2;
      return r;
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic ld, input logic fl);
      ID_VALID = v; ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd;
      ID_REG_WRITE_EN = we; ID_MEM_READ = ld; FLUSH = fl;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //                 v     rs1    rs2    rd     we    ld    fl    stall op1    op2
      // distance 0/1/2/3 forwarding from x5, x8, x9, x11
      tbl[0]  = mk(1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[1]  = mk(1'b1, 5'd5,  5'd5,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
      tbl[2]  = mk(1'b1, 5'd20, 5'd21, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[3]  = mk(1'b1, 5'd20, 5'd21, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[4]  = mk(1'b1, 5'd8,  5'd8,  5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
      tbl[5]  = mk(1'b1, 5'd20, 5'd21, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[6]  = mk(1'b1, 5'd22, 5'd23, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[7]  = mk(1'b1, 5'd22, 5'd23, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[8]  = mk(1'b1, 5'd9,  5'd9,  5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
      tbl[9]  = mk(1'b1, 5'd20, 5'd21, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[10] = mk(1'b1, 5'd20, 5'd21, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[11] = mk(1'b1, 5'd20, 5'd21, 5'd18, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[12] = mk(1'b1, 5'd20, 5'd21, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[13] = mk(1'b1, 5'd11, 5'd11, 5'd24, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      // LW x7 then ADD rs2=x7: one stall cycle, then OP2=10
      tbl[14] = mk(1'b1, 5'd20, 5'd21, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[15] = mk(1'b1, 5'd20, 5'd7,  5'd25, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
      tbl[16] = mk(1'b1, 5'd20, 5'd7,  5'd25, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
      // writes and loads to x0 never forward or stall
      tbl[17] = mk(1'b1, 5'd20, 5'd21, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[18] = mk(1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[19] = mk(1'b1, 5'd0,  5'd0,  5'd26, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      // LW x7 in EX, dependent ADD flushed in ID
      tbl[20] = mk(1'b1, 5'd20, 5'd21, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[21] = mk(1'b1, 5'd7,  5'd7,  5'd27, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      tbl[22] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      // ADDI x3, ORI x3 (reads x3), then readers: youngest producer wins
      tbl[23] = mk(1'b1, 5'd20, 5'd21, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[24] = mk(1'b1, 5'd3,  5'd20, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
      tbl[25] = mk(1'b1, 5'd3,  5'd3,  5'd28, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
      tbl[26] = mk(1'b1, 5'd3,  5'd28, 5'd29, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01);
      // non-writing producer does not forward
      tbl[27] = mk(1'b1, 5'd20, 5'd21, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[28] = mk(1'b1, 5'd30, 5'd3,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      // load-use on rs1
      tbl[29] = mk(1'b1, 5'd20, 5'd21, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      tbl[30] = mk(1'b1, 5'd4,  5'd20, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
      tbl[31] = mk(1'b1, 5'd4,  5'd20, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);

      // Reset held for 3 cycles while a writer of x5 sits in ID
      RESET = 1'b0;
      drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("reset_stall", {1'b0, STALL}, 2'b00);
      chk("reset_op1", OP1_SELECT, 2'b00);
      chk("reset_op2", OP2_SELECT, 2'b00);
      @(posedge CLK);
      #1;
      chk("post_reset_op1", OP1_SELECT, 2'b00);
      chk("post_reset_op2", OP2_SELECT, 2'b00);

      // Table sweep
      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl);
         #1;
         chk($sformatf("v%0d_stall", i), {1'b0, STALL}, {1'b0, tbl[i].stall});
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d_op1", i), OP1_SELECT, tbl[i].op1);
         chk($sformatf("v%0d_op2", i), OP2_SELECT, tbl[i].op2);
      end

      // Mid-stream reset: LW x2 reaches EX, reset clears everything, and a
      // later reader of x2 must neither stall nor forward.
      @(negedge CLK);
      drive(1'b1, 5'd20, 5'd21, 5'd2, 1'b1, 1'b1, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      drive(1'b1, 5'd20, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
      #1;
      chk("pre_reset_stall", {1'b0, STALL}, 2'b01);
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      chk("mid_reset_op1", OP1_SELECT, 2'b00);
      chk("mid_reset_op2", OP2_SELECT, 2'b00);
      @(negedge CLK);
      RESET = 1'b1;
      drive(1'b1, 5'd2, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
      #1;
      chk("after_reset_stall", {1'b0, STALL}, 2'b00);
      @(posedge CLK);
      #1;
      chk("after_reset_op1", OP1_SELECT, 2'b00);
      chk("after_reset_op2", OP2_SELECT, 2'b00);

      @(negedge CLK);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
